// File: rtl/necpu_periph_pkg.sv
// Shared register map and bit positions for the CPU-side LED PWM peripheral.
// Constants only; no logic, no latency, no backpressure.
package necpu_periph_pkg;

  localparam logic [7:0] LED_BASE = 8'h80;

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_DUTY_R = 3'd1,
    OFF_DUTY_G = 3'd2,
    OFF_DUTY_B = 3'd3,
    OFF_PRESC  = 3'd4,
    OFF_STATUS = 3'd5,
    OFF_CNT    = 3'd6,
    OFF_RSVD   = 3'd7
  } reg_off_t;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_LOAD_BIT   = 1;
  localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: shadow/active duty pair plus registered active-low output.
// Output lags cnt by one clock; no backpressure, writes always accepted.
module pwm_channel (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] cnt,
  input  logic       shadow_wr,
  input  logic [7:0] wdata,
  input  logic       load,
  output logic [7:0] shadow,
  output logic       led
);

  logic [7:0] active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= 8'd0;
      active <= 8'd0;
      led    <= 1'b1;
    end else begin
      if (shadow_wr)
        shadow <= wdata;
      // A shadow write landing on a load cycle goes straight through to active.
      if (load)
        active <= shadow_wr ? wdata : shadow;
      led <= ~(en && (cnt < active));
    end
  end

endmodule

// File: rtl/pwm_led_ctrl.sv
// RGB LED PWM peripheral on the CPU byte bus: decode, prescaler, 8-bit period counter.
// Read data one clock after the strobe, LEDs one clock after cnt; no backpressure.
module pwm_led_ctrl
  import necpu_periph_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = LED_BASE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       led_R,
  output logic       led_G,
  output logic       led_B
);

  logic       hit;
  reg_off_t   off;
  logic       wr_hit;
  logic       en;
  logic       wrap_flag;
  logic [7:0] presc;
  logic [7:0] pcnt;
  logic [7:0] cnt;
  logic       tick;
  logic       wrap;
  logic       load_now;
  logic       en_clr;
  logic       status_clr;
  logic       load;
  logic [2:0] duty_wr;
  logic [7:0] shadow_r, shadow_g, shadow_b;
  logic [7:0] rdata;

  assign hit    = (address[7:3] == BASE_ADDR[7:3]);
  assign off    = reg_off_t'(address[2:0]);
  assign wr_hit = write && hit;

  assign load_now   = wr_hit && (off == OFF_CTRL) && din[CTRL_LOAD_BIT];
  assign en_clr     = wr_hit && (off == OFF_CTRL) && !din[CTRL_EN_BIT];
  assign status_clr = wr_hit && (off == OFF_STATUS) && din[STATUS_WRAP_BIT];

  assign tick = en && (pcnt == presc);
  assign wrap = tick && (cnt == 8'hFF);
  assign load = wrap || !en || load_now;

  assign duty_wr[0] = wr_hit && (off == OFF_DUTY_R);
  assign duty_wr[1] = wr_hit && (off == OFF_DUTY_G);
  assign duty_wr[2] = wr_hit && (off == OFF_DUTY_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      presc     <= 8'd0;
      wrap_flag <= 1'b0;
    end else begin
      if (wr_hit && (off == OFF_CTRL))
        en <= din[CTRL_EN_BIT];
      if (wr_hit && (off == OFF_PRESC))
        presc <= din;
      // Set beats clear when a wrap and a STATUS clear share a cycle.
      if (wrap)
        wrap_flag <= 1'b1;
      else if (status_clr)
        wrap_flag <= 1'b0;
    end
  end

  // Clearing EN zeroes the counters on the same edge so the next cycle sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= 8'd0;
      cnt  <= 8'd0;
    end else if (!en || en_clr) begin
      pcnt <= 8'd0;
      cnt  <= 8'd0;
    end else if (tick) begin
      pcnt <= 8'd0;
      cnt  <= cnt + 8'd1;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  always_comb begin
    rdata = 8'd0;
    case (off)
      OFF_CTRL:   rdata = {7'd0, en};
      OFF_DUTY_R: rdata = shadow_r;
      OFF_DUTY_G: rdata = shadow_g;
      OFF_DUTY_B: rdata = shadow_b;
      OFF_PRESC:  rdata = presc;
      OFF_STATUS: rdata = {7'd0, wrap_flag};
      OFF_CNT:    rdata = cnt;
      default:    rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dout <= 8'd0;
    else if (read)
      dout <= (hit && !write) ? rdata : 8'd0;
  end

  pwm_channel u_ch_r (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt       (cnt),
    .shadow_wr (duty_wr[0]),
    .wdata     (din),
    .load      (load),
    .shadow    (shadow_r),
    .led       (led_R)
  );

  pwm_channel u_ch_g (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt       (cnt),
    .shadow_wr (duty_wr[1]),
    .wdata     (din),
    .load      (load),
    .shadow    (shadow_g),
    .led       (led_G)
  );

  pwm_channel u_ch_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt       (cnt),
    .shadow_wr (duty_wr[2]),
    .wdata     (din),
    .load      (load),
    .shadow    (shadow_b),
    .led       (led_B)
  );

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl: reset, duty counts, double buffering, prescaler, bus corners, STATUS race.
module tb_pwm_led_ctrl;

  localparam logic [7:0] BASE = 8'h80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] address = 8'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       led_R, led_G, led_B;

  int tests = 0;
  int fails = 0;

  pwm_led_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .read    (read),
    .address (address),
    .din     (din),
    .dout    (dout),
    .led_R   (led_R),
    .led_G   (led_G),
    .led_B   (led_B)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] q);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    q = dout;
  endtask

  task automatic bus_rw(input logic [7:0] a, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    address = a; din = d; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    q = dout;
  endtask

  // Returns on the first negedge where led_R turns lit after having been off.
  task automatic sync_r_fall(input int budget);
    int  n = 0;
    bit  seen_off = 1'b0;
    bit  done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (led_R) seen_off = 1'b1;
      else if (seen_off) done = 1'b1;
      if (!done && n > budget) begin
        tests++; fails++;
        $display("FAIL sync_r_fall: no led_R period start within %0d cycles", budget);
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] q;
    repeat (3) @(negedge clk);
    tests++;
    if ({led_R, led_G, led_B} !== 3'b111) begin
      fails++; $display("FAIL reset_leds: got %b expected 111", {led_R, led_G, led_B});
    end
    tests++;
    if (dout !== 8'h00) begin
      fails++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    rst = 1'b0;
    bus_read(BASE + 8'd0, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h expected 00", q); end
    bus_read(BASE + 8'd5, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL reset_status: got %h expected 00", q); end
    bus_read(BASE + 8'd6, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL reset_cnt: got %h expected 00", q); end
  endtask

  task automatic test_static_duty;
    logic [7:0] q;
    int lr = 0, lg = 0, lb = 0;
    bus_write(BASE + 8'd4, 8'h00);
    bus_write(BASE + 8'd1, 8'h40);
    bus_write(BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd3, 8'hFF);
    bus_write(BASE + 8'd0, 8'h01);
    bus_read(BASE + 8'd5, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL wrap_before_period: got %h expected 00", q); end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!led_R) lr++;
      if (!led_G) lg++;
      if (!led_B) lb++;
    end
    tests++;
    if (lr != 64) begin fails++; $display("FAIL static_r_lit: got %0d expected 64", lr); end
    tests++;
    if (lg != 0) begin fails++; $display("FAIL static_g_lit: got %0d expected 0", lg); end
    tests++;
    if (lb != 255) begin fails++; $display("FAIL static_b_lit: got %0d expected 255", lb); end
    bus_read(BASE + 8'd5, q);
    tests++;
    if (q !== 8'h01) begin fails++; $display("FAIL wrap_after_period: got %h expected 01", q); end
  endtask

  task automatic test_glitch_free;
    logic [7:0] q;
    int lr = 0;
    sync_r_fall(600);
    repeat (20) @(negedge clk);
    bus_write(BASE + 8'd1, 8'h10);
    bus_read(BASE + 8'd1, q);
    tests++;
    if (q !== 8'h10) begin fails++; $display("FAIL shadow_readback: got %h expected 10", q); end
    // cnt is around 25 here: old duty 0x40 still lights, new 0x10 would not.
    tests++;
    if (led_R !== 1'b0) begin fails++; $display("FAIL active_held: led_R got %b expected 0", led_R); end
    sync_r_fall(600);
    for (int i = 0; i < 256; i++) begin
      if (!led_R) lr++;
      @(negedge clk);
    end
    tests++;
    if (lr != 16) begin fails++; $display("FAIL new_period_r_lit: got %0d expected 16", lr); end
  endtask

  task automatic test_bus_corners;
    logic [7:0] q;
    sync_r_fall(600);
    bus_read(BASE + 8'd6, q);
    tests++;
    if (q !== 8'h02) begin fails++; $display("FAIL cnt_read: got %h expected 02", q); end
    bus_read(BASE + 8'd0, q);
    tests++;
    if (q !== 8'h01) begin fails++; $display("FAIL ctrl_read: got %h expected 01", q); end
    bus_read(BASE + 8'd7, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL off7_read: got %h expected 00", q); end
    bus_read(BASE + 8'd0, q);
    bus_read(BASE + 8'd8, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL miss_read: got %h expected 00", q); end
    bus_read(BASE + 8'd0, q);
    bus_rw(BASE + 8'd2, 8'h55, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL rw_dout: got %h expected 00", q); end
    bus_read(BASE + 8'd2, q);
    tests++;
    if (q !== 8'h55) begin fails++; $display("FAIL rw_write_landed: got %h expected 55", q); end
  endtask

  task automatic test_status_race;
    logic [7:0] q;
    sync_r_fall(600);
    bus_write(BASE + 8'd5, 8'h01);
    bus_read(BASE + 8'd5, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL status_clear: got %h expected 00", q); end
    // Four negedges have passed since sync (cnt=1); land the clear on the 255->0 edge.
    repeat (249) @(negedge clk);
    bus_write(BASE + 8'd5, 8'h01);
    bus_read(BASE + 8'd5, q);
    tests++;
    if (q !== 8'h01) begin fails++; $display("FAIL status_race: got %h expected 01", q); end
  endtask

  task automatic test_prescaler;
    logic [7:0] a, b, q;
    int lr = 0;
    bus_write(BASE + 8'd4, 8'h03);
    bus_read(BASE + 8'd6, a);
    repeat (38) @(negedge clk);
    bus_read(BASE + 8'd6, b);
    tests++;
    if (8'(b - a) !== 8'd10) begin fails++; $display("FAIL presc_rate: got %0d expected 10", 8'(b - a)); end
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (!led_R) lr++;
    end
    tests++;
    if (lr != 64) begin fails++; $display("FAIL presc_r_lit: got %0d expected 64", lr); end
  endtask

  task automatic test_load_now;
    logic [7:0] q;
    sync_r_fall(2100);
    repeat (100) @(negedge clk);
    tests++;
    if (led_G !== 1'b0) begin fails++; $display("FAIL g_lit_before: got %b expected 0", led_G); end
    bus_write(BASE + 8'd2, 8'h00);
    tests++;
    if (led_G !== 1'b0) begin fails++; $display("FAIL g_shadow_only: got %b expected 0", led_G); end
    bus_write(BASE + 8'd0, 8'h03);
    tests++;
    if (led_G !== 1'b0) begin fails++; $display("FAIL g_load_edge: got %b expected 0", led_G); end
    @(negedge clk);
    tests++;
    if (led_G !== 1'b1) begin fails++; $display("FAIL g_load_applied: got %b expected 1", led_G); end
    bus_read(BASE + 8'd0, q);
    tests++;
    if (q !== 8'h01) begin fails++; $display("FAIL load_reads_zero: got %h expected 01", q); end
    bus_write(BASE + 8'd0, 8'h00);
    @(negedge clk);
    tests++;
    if ({led_R, led_G, led_B} !== 3'b111) begin
      fails++; $display("FAIL disable_leds: got %b expected 111", {led_R, led_G, led_B});
    end
    bus_read(BASE + 8'd6, q);
    tests++;
    if (q !== 8'h00) begin fails++; $display("FAIL disable_cnt: got %h expected 00", q); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q;
    bus_write(BASE + 8'd1, 8'h40);
    bus_write(BASE + 8'd0, 8'h01);
    bus_read(BASE + 8'd1, q);
    repeat (6) @(negedge clk);
    tests++;
    if (led_R !== 1'b0) begin fails++; $display("FAIL mid_r_lit: got %b expected 0", led_R); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({led_R, led_G, led_B} !== 3'b111) begin
      fails++; $display("FAIL async_off: got %b expected 111", {led_R, led_G, led_B});
    end
    tests++;
    if (dout !== 8'h00) begin fails++; $display("FAIL async_dout: got %h expected 00", dout); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_read(BASE + 8'(i), q);
      tests++;
      if (q !== 8'h00) begin fails++; $display("FAIL post_reset_off%0d: got %h expected 00", i, q); end
    end
  endtask

  initial begin
    test_reset();
    test_static_duty();
    test_glitch_free();
    test_bus_corners();
    test_status_race();
    test_prescaler();
    test_load_now();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pwm_led_ctrl.md
Name: pwm_led_ctrl

Overview:
- Memory-mapped RGB LED PWM peripheral on the CPU's 8-bit write/read bus.
- Replaces the single static LED register in the top level with per-channel 8-bit brightness, a programmable prescaler and glitch-free duty updates.
- Sits directly downstream of the CPU. It decodes `address`, absorbs writes, returns read data on `dout`, and drives the active-low `led_R`, `led_G` and `led_B` pins.

Parameters:
- `BASE_ADDR`, 8'h80, base address of the 8-byte register window (`BASE_ADDR[2:0]` must be 0).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `write` input 1: CPU write strobe, one cycle per access.
- `read` input 1: CPU read strobe, one cycle per access.
- `address` input 8: CPU byte address.
- `din` input 8: write data from CPU.
- `dout` output 8: registered read data to CPU.
- `led_R` output 1: red LED, active-low (0 = lit).
- `led_G` output 1: green LED, active-low.
- `led_B` output 1: blue LED, active-low.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous, active-high.
- Reset values: all registers 0, `dout`=0, `led_R`/`led_G`/`led_B`=1 (off), counters 0.
- Decode: hit when `address[7:3]==BASE_ADDR[7:3]`; the offset is `address[2:0]`.
- Register map:
  - 0 CTRL (rw): bit0 EN, bit1 LOAD_NOW (write-1 pulse, reads 0); bits 7:2 read 0.
  - 1 DUTY_R, 2 DUTY_G, 3 DUTY_B (rw): shadow duty; a read returns the shadow value.
  - 4 PRESC (rw): prescaler terminal count.
  - 5 STATUS: bit0 WRAP sticky flag; write 1 to bit0 to clear. Other bits read 0.
  - 6 CNT (ro): current PWM counter.
  - 7: reads 0, writes ignored.
- Writes: take effect at the clock edge where `write`=1 and the address hits. Writes to read-only or unmapped offsets are ignored.
- Reads: `dout` is registered. The value is valid the cycle after `read`=1 and holds until the next access. If the access is a miss, `dout` is 0. If `write` and `read` are both high, the write is performed and `dout` is 0.
- Prescaler: `pcnt` counts 0..PRESC. `tick`=1 when `pcnt==PRESC` and EN=1, at which point `pcnt` returns to 0. PRESC=0 gives a tick every cycle.
- PWM counter: 8-bit `cnt` increments on `tick` and wraps 255→0. The wrap sets STATUS.WRAP.
  - A STATUS clear on the same cycle as a wrap loses to the set (the flag stays 1).
- Double-buffered duty: active duty registers load from the shadow registers in these cases:
  - on the tick that wraps `cnt` to 0;
  - on every cycle while EN=0;
  - on a LOAD_NOW write.
  - If a shadow write and a load coincide, the active register gets the new `din` value.
- Enable/disable: clearing EN freezes `pcnt` and `cnt` at 0 on the next cycle and forces all LEDs off. Setting EN starts the count from 0.
- Output: `led_X` is registered as `~(EN && cnt < duty_active_X)`, giving one cycle of latency from `cnt`.
  - Duty 0 = always off; duty 255 = lit 255/256 of the period.
  - The period is 256*(PRESC+1) clocks.
- Reset mid-period: outputs go off asynchronously. The shadow registers are cleared with everything else.

Decomposition:
- Shared package `necpu_periph_pkg`:
  - register offset constants: OFF_CTRL=0, OFF_DUTY_R=1, OFF_DUTY_G=2, OFF_DUTY_B=3, OFF_PRESC=4, OFF_STATUS=5, OFF_CNT=6;
  - CTRL/STATUS bit indices;
  - LED_BASE default 8'h80.
- One natural sub-module, `pwm_channel`: holds a shadow→active duty register plus the compare and output flop. It is instantiated three times. The bus decode, prescaler and counter live in `pwm_led_ctrl`.

Test Plan:
1. Reset check: assert `rst` mid-operation with EN=1 and DUTY_R=8'h40 → LEDs =1 immediately, all register reads return 0 after release.
2. Static duty: PRESC=0, DUTY_R=8'h40, DUTY_G=0, DUTY_B=8'hFF, EN=1 → over 256 clocks the lit counts are `led_R` 64, `led_G` 0, `led_B` 255. WRAP=1 after the first period.
3. Glitch-free update: mid-period, write DUTY_R=8'h10 → the active duty is unchanged until `cnt` wraps. The next period lights `led_R` for 16 clocks, and a read of DUTY_R returns 8'h10 immediately.
4. Prescaler and LOAD_NOW: PRESC=3 → `cnt` advances every 4 clocks, period 1024 clocks. Writing CTRL=8'h03 mid-period applies the shadow duty on the next clock.
5. Bus corner cases:
   - read CNT while running → `dout` equals `cnt` one cycle later;
   - read offset 7 → 0;
   - read address BASE_ADDR+8 → 0;
   - simultaneous read+write to DUTY_G → write lands, `dout`=0.
6. STATUS race: write 1 to STATUS bit0 on the same cycle as a wrap → WRAP reads 1. A clear on a non-wrap cycle → WRAP reads 0.
